// File: rtl/iob_cache_wtbuf_pkg.sv
// -----------------------------------------------------------------------------
// iob_cache_wtbuf_pkg
// Shared entry layout for the write-through buffer. Each buffered entry is
// packed as {addr, wdata, wstrb}: wstrb sits in the LSBs, wdata above it and
// addr in the MSBs. These helpers provide the entry width and the field
// offsets used to pack and unpack an entry. Both the buffer control and its
// storage use them.
// -----------------------------------------------------------------------------
package iob_cache_wtbuf_pkg;

  function automatic int wtbuf_entry_w(input int addr_w, input int data_w);
    return addr_w + data_w + data_w / 8;
  endfunction

  function automatic int wtbuf_strb_lsb(input int data_w);
    return 0 * data_w;
  endfunction

  function automatic int wtbuf_data_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int wtbuf_addr_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

endpackage

// File: rtl/iob_cache_wtbuf_mem.sv
// -----------------------------------------------------------------------------
// iob_cache_wtbuf_mem
// DEPTH x ENTRY_W register file. It has one synchronous write port and one
// asynchronous read port, and it holds no control logic. The storage is never
// reset, because stale contents are unreachable once the pointers are cleared.
//   clk    : clock
//   we     : write enable
//   waddr  : write index
//   wdata  : entry to write
//   raddr  : read index
//   rdata  : entry at raddr (combinational)
// -----------------------------------------------------------------------------
module iob_cache_wtbuf_mem
  import iob_cache_wtbuf_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2,
  parameter int ENTRY_W    = 68
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [ENTRY_W-1:0]    wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [ENTRY_W-1:0]    rdata
);

  logic [ENTRY_W-1:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/iob_cache_wtbuf.sv
// -----------------------------------------------------------------------------
// iob_cache_wtbuf
// Write-through buffer between the cache front-end write path and the
// back-end memory write channel. Accepted CPU writes are queued as
// {addr, wdata, wstrb} and drained in order with a valid/ready handshake.
// The head entry is presented first-word-fall-through.
//   clk, reset           : clock, synchronous active-high reset
//   push, push_addr,
//   push_wdata, push_wstrb : front-end write request
//   be_valid, be_addr,
//   be_wdata, be_wstrb   : head entry towards the back-end
//   be_ready             : back-end accepts the head entry
//   wtbuf_full/empty     : occupancy status for the control register block
//   level                : registered occupancy, only present when
//                          IOB_CACHE_WTBUF_LEVEL_EN is defined
// -----------------------------------------------------------------------------
module iob_cache_wtbuf
  import iob_cache_wtbuf_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [ADDR_W-1:0]     push_addr,
  input  logic [DATA_W-1:0]     push_wdata,
  input  logic [DATA_W/8-1:0]   push_wstrb,
  output logic                  be_valid,
  output logic [ADDR_W-1:0]     be_addr,
  output logic [DATA_W-1:0]     be_wdata,
  output logic [DATA_W/8-1:0]   be_wstrb,
  input  logic                  be_ready,
  output logic                  wtbuf_full,
  output logic                  wtbuf_empty
`ifdef IOB_CACHE_WTBUF_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]   level
`endif
);

  localparam int STRB_W   = DATA_W / 8;
  localparam int PTR_W    = DEPTH_LOG2;
  localparam int LVL_W    = DEPTH_LOG2 + 1;
  localparam int ENTRY_W  = wtbuf_entry_w(ADDR_W, DATA_W);
  localparam int STRB_LSB = wtbuf_strb_lsb(DATA_W);
  localparam int DATA_LSB = wtbuf_data_lsb(DATA_W);
  localparam int ADDR_LSB = wtbuf_addr_lsb(DATA_W);
  localparam logic [LVL_W-1:0] DEPTH_LVL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic               pop;
  logic               push_acc;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  // Flags come from the level only. Pointer equality would be ambiguous
  // between the full and empty cases.
  assign wtbuf_full  = (level_q == DEPTH_LVL);
  assign wtbuf_empty = (level_q == '0);
  assign be_valid    = ~wtbuf_empty;

  assign pop      = be_valid & be_ready;
  // While full, a push still fits if the head leaves in the same cycle.
  assign push_acc = push & (~wtbuf_full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_acc, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  assign wr_entry = {push_addr, push_wdata, push_wstrb};

  iob_cache_wtbuf_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .ENTRY_W    (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign be_addr  = rd_entry[ADDR_LSB +: ADDR_W];
  assign be_wdata = rd_entry[DATA_LSB +: DATA_W];
  assign be_wstrb = rd_entry[STRB_LSB +: STRB_W];

`ifdef IOB_CACHE_WTBUF_LEVEL_EN
  assign level = level_q;
`endif

endmodule

// File: tb/tb_iob_cache_wtbuf.sv
// -----------------------------------------------------------------------------
// tb_iob_cache_wtbuf
// Self-checking bench for iob_cache_wtbuf with default parameters
// (ADDR_W=32, DATA_W=32, DEPTH_LOG2=2). The reference model is a queue of
// entries bounded at DEPTH. It honours the accept/drop rule, FIFO order and
// the clearing effect of reset. Defining IOB_CACHE_WTBUF_LEVEL_EN also
// checks the level port.
// -----------------------------------------------------------------------------
module tb_iob_cache_wtbuf;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int DEPTH_LOG2 = 2;
  localparam int DEPTH      = 2**DEPTH_LOG2;

  logic              clk = 1'b0;
  logic              reset;
  logic              push;
  logic [ADDR_W-1:0] push_addr;
  logic [DATA_W-1:0] push_wdata;
  logic [3:0]        push_wstrb;
  logic              be_valid;
  logic [ADDR_W-1:0] be_addr;
  logic [DATA_W-1:0] be_wdata;
  logic [3:0]        be_wstrb;
  logic              be_ready;
  logic              wtbuf_full;
  logic              wtbuf_empty;
`ifdef IOB_CACHE_WTBUF_LEVEL_EN
  logic [DEPTH_LOG2:0] level;
`endif

  iob_cache_wtbuf #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_addr   (push_addr),
    .push_wdata  (push_wdata),
    .push_wstrb  (push_wstrb),
    .be_valid    (be_valid),
    .be_addr     (be_addr),
    .be_wdata    (be_wdata),
    .be_wstrb    (be_wstrb),
    .be_ready    (be_ready),
    .wtbuf_full  (wtbuf_full),
    .wtbuf_empty (wtbuf_empty)
`ifdef IOB_CACHE_WTBUF_LEVEL_EN
    ,
    .level       (level)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: entries in arrival order, oldest first.
  logic [ADDR_W-1:0] mq_addr [$];
  logic [DATA_W-1:0] mq_data [$];
  logic [3:0]        mq_strb [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Compares the DUT outputs with the model, drives one cycle of stimulus
  // and then advances the model. The task is entered and left on a negedge.
  task automatic step(input logic p, input logic [ADDR_W-1:0] a,
                      input logic [DATA_W-1:0] d, input logic [3:0] s,
                      input logic r, input logic rs);
    bit pop_m, acc_m;
    int n;
    n = mq_addr.size();
    check("be_valid", 64'(be_valid), 64'(n != 0));
    check("empty", 64'(wtbuf_empty), 64'(n == 0));
    check("full", 64'(wtbuf_full), 64'(n == DEPTH));
`ifdef IOB_CACHE_WTBUF_LEVEL_EN
    check("level", 64'(level), 64'(n));
`endif
    if (n != 0) begin
      check("be_addr", 64'(be_addr), 64'(mq_addr[0]));
      check("be_wdata", 64'(be_wdata), 64'(mq_data[0]));
      check("be_wstrb", 64'(be_wstrb), 64'(mq_strb[0]));
    end
    push = p; push_addr = a; push_wdata = d; push_wstrb = s;
    be_ready = r; reset = rs;
    pop_m = r && (n != 0);
    acc_m = p && ((n < DEPTH) || pop_m);
    @(posedge clk);
    if (rs) begin
      mq_addr.delete(); mq_data.delete(); mq_strb.delete();
    end else begin
      if (pop_m) begin
        void'(mq_addr.pop_front()); void'(mq_data.pop_front()); void'(mq_strb.pop_front());
      end
      if (acc_m) begin
        mq_addr.push_back(a); mq_data.push_back(d); mq_strb.push_back(s);
      end
    end
    @(negedge clk);
  endtask

  task automatic push_only(input logic [ADDR_W-1:0] a, input logic r);
    step(1'b1, a, $urandom, 4'($urandom), r, 1'b0);
  endtask

  task automatic idle(input logic r);
    step(1'b0, $urandom, $urandom, 4'($urandom), r, 1'b0);
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; push_addr = '0; push_wdata = '0;
    push_wstrb = '0; be_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_empty", 64'(wtbuf_empty), 64'd1);
    check("rst_full", 64'(wtbuf_full), 64'd0);
    check("rst_valid", 64'(be_valid), 64'd0);

    // A single push becomes visible the next cycle
    step(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
    check("first_valid", 64'(be_valid), 64'd1);
    check("first_addr", 64'(be_addr), 64'h10);
    check("first_data", 64'(be_wdata), 64'hDEADBEEF);
    check("first_empty", 64'(wtbuf_empty), 64'd0);
    idle(1'b1);

    // Fill, drop the overflow push, then drain in order
    for (int i = 0; i < DEPTH; i++) push_only(32'(i * 4), 1'b0);
    check("fill_full", 64'(wtbuf_full), 64'd1);
    push_only(32'h50, 1'b0);
    check("drop_full", 64'(wtbuf_full), 64'd1);
    for (int i = 0; i < DEPTH; i++) begin
      check("drain_order", 64'(be_addr), 64'(i * 4));
      idle(1'b1);
    end
    check("drained_empty", 64'(wtbuf_empty), 64'd1);

    // Simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) push_only(32'(i * 4), 1'b0);
    push_only(32'h60, 1'b1);
    check("pp_full", 64'(wtbuf_full), 64'd1);
    for (int i = 1; i <= DEPTH; i++) begin
      check("pp_order", 64'(be_addr), (i == DEPTH) ? 64'h60 : 64'(i * 4));
      idle(1'b1);
    end

    // Continuous streaming: occupancy stays at one, and the pointers wrap
    push_only(32'h100, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      check("stream_head", 64'(be_addr), 64'(32'h100 + 4 * (i - 1)));
      check("stream_notfull", 64'(wtbuf_full), 64'd0);
      push_only(32'(32'h100 + 4 * i), 1'b1);
    end
    idle(1'b1);
    check("stream_empty", 64'(wtbuf_empty), 64'd1);

    // Reset mid-drain discards everything
    for (int i = 0; i < 3; i++) push_only(32'(32'h200 + 4 * i), 1'b0);
    step(1'b0, '0, '0, '0, 1'b1, 1'b1);
    check("rst2_empty", 64'(wtbuf_empty), 64'd1);
    check("rst2_valid", 64'(be_valid), 64'd0);
    idle(1'b1);
    check("rst2_stays_empty", 64'(be_valid), 64'd0);

`ifdef IOB_CACHE_WTBUF_LEVEL_EN
    // Level tracking
    push_only(32'h300, 1'b0);
    check("lvl1", 64'(level), 64'd1);
    push_only(32'h304, 1'b0);
    check("lvl2", 64'(level), 64'd2);
    push_only(32'h308, 1'b0);
    check("lvl3", 64'(level), 64'd3);
    idle(1'b1);
    check("lvl2b", 64'(level), 64'd2);
    idle(1'b1);
    idle(1'b1);
`endif

    // Randomised traffic, including zero strobes and occasional resets
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 60), $urandom, $urandom,
           4'($urandom_range(0, 3) == 0 ? 0 : $urandom),
           1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 2));
    end
    idle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
